// File: rtl/hps_node_fetch_if.sv
// Read port between the node fetcher (master) and HPS-bridge shared memory (slave).
// rd_req is held with a stable rd_addr until rd_ack, and rd_ack completes the request.
// Exactly one rd_valid/rd_data beat follows each acked request, no earlier than the next cycle.
interface hps_node_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, rd_addr, input rd_ack, rd_valid, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_valid, rd_data);
endinterface

// File: rtl/hps_node_fetch.sv
// Loads up to NUM_NODES node records from shared memory into one flat vector,
// stopping early on a SENTINEL in word 0 of a record, on a read timeout, or on abort.
module hps_node_fetch #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 16,
  parameter int                WORDS_PER_NODE = 17,
  parameter int                NUM_NODES      = 2,
  parameter int                ADDR_STEP      = 2,
  parameter logic [DATA_W-1:0] SENTINEL       = DATA_W'(16'hFFFF),
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [ADDR_W-1:0]                         base_addr,
  hps_node_fetch_if.master                          rd,
  output logic [NUM_NODES*WORDS_PER_NODE*DATA_W-1:0] node_data,
  output logic [$clog2(NUM_NODES+1)-1:0]            nodes_loaded,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      sentinel_hit,
  output logic                                      timeout_err,
  output logic [1:0]                                dbg_state
);
  localparam int TOTAL = NUM_NODES * WORDS_PER_NODE;
  localparam int NDW   = TOTAL * DATA_W;
  localparam int I_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int W_W   = (WORDS_PER_NODE > 1) ? $clog2(WORDS_PER_NODE) : 1;
  localparam int NL_W  = $clog2(NUM_NODES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [I_W-1:0]  LAST_I = I_W'(TOTAL - 1);
  localparam logic [W_W-1:0]  LAST_W = W_W'(WORDS_PER_NODE - 1);
  localparam logic [TO_W-1:0] LAST_T = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [I_W-1:0]    i_q, i_d;
  logic [W_W-1:0]    w_q, w_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [NDW-1:0]    nd_q, nd_d;
  logic [NL_W-1:0]   nl_q, nl_d;
  logic              sent_q, sent_d;
  logic              terr_q, terr_d;
  int                slot;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    i_d     = i_q;
    w_d     = w_q;
    tmo_d   = tmo_q;
    nd_d    = nd_q;
    nl_d    = nl_q;
    sent_d  = sent_q;
    terr_d  = terr_q;
    slot    = (TOTAL - 1 - int'(i_q)) * DATA_W;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          i_d     = '0;
          w_d     = '0;
          tmo_d   = '0;
          nd_d    = '0;
          nl_d    = '0;
          sent_d  = 1'b0;
          terr_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rd.rd_ack) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // abort outranks a same-cycle data beat and the timeout
        if (abort) begin
          state_d = S_IDLE;
        end else if (rd.rd_valid) begin
          if (w_q == '0 && rd.rd_data == SENTINEL) begin
            sent_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            nd_d[slot +: DATA_W] = rd.rd_data;
            if (w_q == LAST_W) begin
              nl_d = nl_q + NL_W'(1);
              w_d  = '0;
            end else begin
              w_d = w_q + W_W'(1);
            end
            if (i_q == LAST_I) begin
              state_d = S_DONE;
            end else begin
              i_d     = i_q + I_W'(1);
              addr_d  = addr_q + ADDR_W'(ADDR_STEP);
              state_d = S_REQ;
            end
          end
        end else if (tmo_q == LAST_T) begin
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      i_q     <= '0;
      w_q     <= '0;
      tmo_q   <= '0;
      nd_q    <= '0;
      nl_q    <= '0;
      sent_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      i_q     <= i_d;
      w_q     <= w_d;
      tmo_q   <= tmo_d;
      nd_q    <= nd_d;
      nl_q    <= nl_d;
      sent_q  <= sent_d;
      terr_q  <= terr_d;
    end
  end

  assign rd.rd_req     = (state_q == S_REQ);
  assign rd.rd_addr    = addr_q;
  assign node_data     = nd_q;
  assign nodes_loaded  = nl_q;
  assign busy          = (state_q == S_REQ) || (state_q == S_WAIT);
  assign done          = (state_q == S_DONE);
  assign sentinel_hit  = sent_q;
  assign timeout_err   = terr_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_hps_node_fetch.sv
// Directed bench for hps_node_fetch: a negedge-driven memory responder inside one task,
// with an expected-address queue and a bench-built node_data image.
module tb_hps_node_fetch;
  localparam int TOTAL = 34;
  localparam int NDW   = TOTAL * 16;
  localparam logic [1:0] S_IDLE = 2'd0;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [15:0]     base_addr;
  logic [NDW-1:0]  node_data;
  logic [1:0]      nodes_loaded;
  logic            busy, done, sentinel_hit, timeout_err;
  logic [1:0]      dbg_state;

  hps_node_fetch_if #(.ADDR_W(16), .DATA_W(16)) rd_if ();

  hps_node_fetch #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .rd           (rd_if.master),
    .node_data    (node_data),
    .nodes_loaded (nodes_loaded),
    .busy         (busy),
    .done         (done),
    .sentinel_hit (sentinel_hit),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  logic [15:0]    exp_q[$];
  logic [NDW-1:0] exp_nd;
  int             n_reads, n_done, done_cyc, wait_cycles;
  bit             stuck;

  task automatic chk(input string tag, input logic [NDW-1:0] obs, input logic [NDW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] slice(input int idx);
    return node_data[(TOTAL-1-idx)*16 +: 16];
  endfunction

  task automatic clear_inputs();
    abort = 1'b0;
    rd_if.rd_ack = 1'b0;
    rd_if.rd_valid = 1'b0;
    rd_if.rd_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_req"}, rd_if.rd_req, 0);
    chk({tag, "_rd_addr"}, rd_if.rd_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_node_data"}, node_data, 0);
    chk({tag, "_nodes_loaded"}, nodes_loaded, 0);
    chk({tag, "_flags"}, {sentinel_hit, timeout_err}, 0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // Immediate ack in the request cycle, data one cycle later; data = address unless overridden.
  task automatic run_fetch(input logic [15:0] base, input int sent_idx, input int hold_idx,
                           input int abort_idx, input int rst_idx, input int busy_start_cyc);
    logic [15:0] cur_addr, dat;
    int cur_idx, cyc;
    bit pending, fin, aborted;
    exp_q.delete();
    for (int j = 0; j < TOTAL; j++) exp_q.push_back(base + 16'(2 * j));
    exp_nd = '0;
    n_reads = 0; n_done = 0; done_cyc = -1; wait_cycles = 0; stuck = 0;
    cur_addr = '0; cur_idx = 0; cyc = 0; pending = 0; fin = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = (cyc == busy_start_cyc);
      base_addr = start ? 16'h1234 : 16'h0000;
      clear_inputs();
      if (aborted) begin
        chk("abort_state", dbg_state, S_IDLE);
        chk("abort_busy", busy, 0);
        fin = 1;
      end else if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (n_done > 0) begin
        fin = 1;
      end else if (cyc > 400) begin
        stuck = 1;
        fin = 1;
      end else if (rd_if.rd_req) begin
        if (n_reads == rst_idx) begin
          #2 reset = 1'b0;
          #1 check_all_zero("async_reset");
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        n_reads++;
        cur_addr = rd_if.rd_addr;
        cur_idx = n_reads - 1;
        rd_if.rd_ack = 1'b1;
        pending = 1;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_read observed_addr=%0h expected=no_read", rd_if.rd_addr);
        end
        if (exp_q.size() != 0) chk("rd_addr", rd_if.rd_addr, exp_q.pop_front());
      end else if (pending && busy) begin
        if (cur_idx == hold_idx) begin
          wait_cycles++;
        end else begin
          dat = (cur_idx == sent_idx) ? 16'hFFFF : cur_addr;
          rd_if.rd_valid = 1'b1;
          rd_if.rd_data = dat;
          pending = 0;
          if (cur_idx == abort_idx) begin
            abort = 1'b1;
            aborted = 1;
          end else if (!((cur_idx % 17) == 0 && dat == 16'hFFFF)) begin
            exp_nd[(TOTAL-1-cur_idx)*16 +: 16] = dat;
          end
        end
      end
    end
    chk("no_hang", stuck, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base_addr = '0;
    clear_inputs();
    #3 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Full fetch; a start with another base mid-fetch must be ignored.
    run_fetch(16'h0800, -1, -1, -1, -1, 5);
    chk("full_reads", n_reads, 34);
    chk("full_node_data", node_data, exp_nd);
    chk("full_w0", slice(0), 16'h0800);
    chk("full_w33", slice(33), 16'h0842);
    chk("full_loaded", nodes_loaded, 2);
    chk("full_done_count", n_done, 1);
    chk("full_done_cycle", done_cyc, 69);
    chk("full_flags", {sentinel_hit, timeout_err}, 0);

    // Sentinel in word 0 of node 1.
    run_fetch(16'h0800, 17, -1, -1, -1, -1);
    chk("sent_reads", n_reads, 18);
    chk("sent_loaded", nodes_loaded, 1);
    chk("sent_hit", sentinel_hit, 1);
    chk("sent_node1_zero", node_data[17*16-1:0], 0);
    chk("sent_node_data", node_data, exp_nd);
    chk("sent_done_count", n_done, 1);

    // Sentinel value in a non-zero word is plain data.
    run_fetch(16'h0800, 3, -1, -1, -1, -1);
    chk("data_ffff_reads", n_reads, 34);
    chk("data_ffff_hit", sentinel_hit, 0);
    chk("data_ffff_w3", slice(3), 16'hFFFF);
    chk("data_ffff_loaded", nodes_loaded, 2);

    // Read timeout on word 5.
    run_fetch(16'h0800, -1, 5, -1, -1, -1);
    chk("tmo_reads", n_reads, 6);
    chk("tmo_wait_cycles", wait_cycles, 8);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_done_count", n_done, 1);
    chk("tmo_loaded", nodes_loaded, 0);
    chk("tmo_node_data", node_data, exp_nd);

    // Abort coincident with the data beat of word 20.
    run_fetch(16'h0800, -1, -1, 20, -1, -1);
    chk("abort_reads", n_reads, 21);
    chk("abort_done_count", n_done, 0);
    chk("abort_loaded", nodes_loaded, 1);
    chk("abort_w20", slice(20), 16'h0000);
    chk("abort_w19", slice(19), 16'h0826);
    chk("abort_node_data", node_data, exp_nd);

    // Asynchronous reset mid-fetch, then a clean fetch that wraps the address space.
    run_fetch(16'h0800, -1, -1, -1, 10, -1);
    chk("rst_reads", n_reads, 10);
    run_fetch(16'hFFF0, -1, -1, -1, -1, -1);
    chk("wrap_reads", n_reads, 34);
    chk("wrap_w0", slice(0), 16'hFFF0);
    chk("wrap_w33", slice(33), 16'h0032);
    chk("wrap_node_data", node_data, exp_nd);
    chk("wrap_loaded", nodes_loaded, 2);
    chk("wrap_done_cycle", done_cyc, 69);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
